// File: rtl/seq_updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_updown_counter_param
//  Description : Up/down counter with a programmable step, sync clear/load,
//                and a registered boundary event. Wraps or clamps.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_updown_counter_param #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned STEP     = 1,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             evt,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH:0]   c_STEP = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] c_MAX  = '1;
   localparam logic [WIDTH-1:0] c_ZERO = '0;

   logic [WIDTH-1:0] r_q;
   logic             r_evt;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_cross;
   logic [WIDTH-1:0] w_wrap;
   logic [WIDTH-1:0] w_next;

   // The extra MSB is the carry (up) or borrow (down): it flags a crossing.
   assign w_sum   = {1'b0, r_q} + c_STEP;
   assign w_diff  = {1'b0, r_q} - c_STEP;
   assign w_cross = up ? w_sum[WIDTH] : w_diff[WIDTH];
   assign w_wrap  = up ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];

   generate
      if (SATURATE) begin : g_clamp
         assign w_next = w_cross ? (up ? c_MAX : c_ZERO) : w_wrap;
      end else begin : g_wrap
         assign w_next = w_wrap;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= c_ZERO;
         r_evt <= 1'b0;
      end else if (clear) begin
         r_q   <= c_ZERO;
         r_evt <= 1'b0;
      end else if (load) begin
         r_q   <= load_val;
         r_evt <= 1'b0;
      end else if (en) begin
         r_q   <= w_next;
         r_evt <= w_cross;
      end else begin
         r_evt <= 1'b0;
      end
   end

   assign q      = r_q;
   assign evt    = r_evt;
   assign at_max = (r_q == c_MAX);
   assign at_min = (r_q == c_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_seq_updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_updown_counter_param
//  Description : Bench for three counter configurations against an integer
//                model, with directed boundary cases and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_updown_counter_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       en = 1'b0;
   logic       up = 1'b0;

   logic [7:0] q0, q1, q2;
   logic       evt0, evt1, evt2;
   logic       mx0, mx1, mx2, mn0, mn1, mn2;

   int  checks = 0;
   int  errors = 0;
   bit  run_chk = 1'b0;

   // Instance 0: step 1 wrap, 1: step 3 wrap, 2: step 4 clamp.
   int  c_STEPS [3] = '{1, 3, 4};
   bit  c_SATS  [3] = '{1'b0, 1'b0, 1'b1};
   int  mq   [3] = '{0, 0, 0};
   bit  mevt [3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   seq_updown_counter_param #(.WIDTH(8), .STEP(1), .SATURATE(1'b0)) u0 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up(up), .q(q0), .evt(evt0), .at_max(mx0), .at_min(mn0));
   seq_updown_counter_param #(.WIDTH(8), .STEP(3), .SATURATE(1'b0)) u1 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up(up), .q(q1), .evt(evt1), .at_max(mx1), .at_min(mn1));
   seq_updown_counter_param #(.WIDTH(8), .STEP(4), .SATURATE(1'b1)) u2 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up(up), .q(q2), .evt(evt2), .at_max(mx2), .at_min(mn2));

   // Reference: plain integer arithmetic on the 0..255 range.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         int cand;
         if (rst || clear) begin
            mq[i] = 0;  mevt[i] = 1'b0;
         end else if (load) begin
            mq[i] = int'(load_val);  mevt[i] = 1'b0;
         end else if (en) begin
            cand = up ? mq[i] + c_STEPS[i] : mq[i] - c_STEPS[i];
            if (cand > 255) begin
               mevt[i] = 1'b1;
               mq[i]   = c_SATS[i] ? 255 : cand - 256;
            end else if (cand < 0) begin
               mevt[i] = 1'b1;
               mq[i]   = c_SATS[i] ? 0 : cand + 256;
            end else begin
               mevt[i] = 1'b0;
               mq[i]   = cand;
            end
         end else begin
            mevt[i] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int i, input logic [7:0] q, input logic e,
                           input logic mx, input logic mn);
      chk($sformatf("u%0d_q", i),      int'(q),  mq[i]);
      chk($sformatf("u%0d_evt", i),    int'(e),  int'(mevt[i]));
      chk($sformatf("u%0d_at_max", i), int'(mx), int'(mq[i] == 255));
      chk($sformatf("u%0d_at_min", i), int'(mn), int'(mq[i] == 0));
   endtask

   always @(negedge clk) begin
      if (run_chk) begin
         cmp_inst(0, q0, evt0, mx0, mn0);
         cmp_inst(1, q1, evt1, mx1, mn1);
         cmp_inst(2, q2, evt2, mx2, mn2);
      end
   end

   task automatic drive(input bit c, input bit l, input logic [7:0] lv,
                        input bit e, input bit u);
      clear = c;  load = l;  load_val = lv;  en = e;  up = u;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      run_chk = 1'b1;
      chk("reset_q", int'(q0), 0);
      chk("reset_at_min", int'(mn0), 1);
      chk("reset_at_max", int'(mx0), 0);
      rst = 1'b0;

      // Wrap up across the top, step 1.
      drive(0, 1, 8'hFE, 0, 0);
      drive(0, 0, 8'h00, 1, 1);
      chk("t1_q_ff", int'(q0), 8'hFF);  chk("t1_evt0", int'(evt0), 0);
      chk("t1_at_max", int'(mx0), 1);
      drive(0, 0, 8'h00, 1, 1);
      chk("t1_q_00", int'(q0), 8'h00);  chk("t1_evt1", int'(evt0), 1);
      drive(0, 0, 8'h00, 1, 1);
      chk("t1_q_01", int'(q0), 8'h01);  chk("t1_evt2", int'(evt0), 0);

      // Wrap down across zero, step 3.
      drive(0, 1, 8'h01, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      chk("t2_q_fe", int'(q1), 8'hFE);  chk("t2_evt1", int'(evt1), 1);
      drive(0, 0, 8'h00, 1, 0);
      chk("t2_q_fb", int'(q1), 8'hFB);  chk("t2_evt0", int'(evt1), 0);

      // Clamp at top, step 4, including repeated counting at the limit.
      drive(0, 1, 8'hFD, 0, 0);
      drive(0, 0, 8'h00, 1, 1);
      chk("t3_q_ff_a", int'(q2), 8'hFF);  chk("t3_evt_a", int'(evt2), 1);
      drive(0, 0, 8'h00, 1, 1);
      chk("t3_q_ff_b", int'(q2), 8'hFF);  chk("t3_evt_b", int'(evt2), 1);

      // Clamp at bottom.
      drive(0, 1, 8'h02, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      chk("t4_q_00", int'(q2), 8'h00);  chk("t4_evt", int'(evt2), 1);
      chk("t4_at_min", int'(mn2), 1);

      // Exact landing on a limit gives no event.
      drive(0, 1, 8'h04, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      chk("land0_q", int'(q2), 8'h00);  chk("land0_evt", int'(evt2), 0);

      // Priority: clear over load over en.
      drive(0, 1, 8'h33, 0, 0);
      drive(1, 1, 8'h55, 1, 1);
      chk("t5_clear_q", int'(q0), 8'h00);
      drive(0, 1, 8'h55, 1, 1);
      chk("t5_load_q", int'(q0), 8'h55);

      // Asynchronous reset mid-count.
      drive(1, 0, 8'h00, 0, 0);
      for (int k = 0; k < 16; k++) drive(0, 0, 8'h00, 1, 1);
      chk("t6_q_10", int'(q0), 8'h10);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_q", int'(q0), 0);
      chk("t6_async_at_min", int'(mn0), 1);
      en = 1'b1;  up = 1'b1;
      @(posedge clk);  @(posedge clk);  @(negedge clk);
      chk("t6_hold_q", int'(q0), 0);
      rst = 1'b0;
      drive(0, 0, 8'h00, 1, 1);
      chk("t6_after_q", int'(q0), 8'h01);

      // Random traffic, with loads biased towards the limits.
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] lv;
         lv = 8'($urandom);
         if ($urandom_range(0, 1) == 0) lv = (lv[0]) ? 8'hFF - 8'(lv[2:1]) : 8'(lv[2:1]);
         clear = ($urandom_range(0, 31) == 0);
         load  = ($urandom_range(0, 7) == 0);
         load_val = lv;
         en    = ($urandom_range(0, 3) != 0);
         up    = ($urandom_range(0, 2) != 0) ^ n[6];
         if ($urandom_range(0, 63) == 0) begin
            #3 rst = 1'b1;
            #1;
            chk("rnd_async_q0", int'(q0), 0);
            chk("rnd_async_q2", int'(q2), 0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
         end else begin
            @(posedge clk);
            @(negedge clk);
         end
      end

      run_chk = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_updown_counter_param.md
SEQ_UPDOWN_COUNTER_PARAM -- requirements
Module: seq_updown_counter_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter STEP, default 1, giving the increment/decrement magnitude; legal range 1..2**WIDTH-1.
REQ-003 The block SHALL have parameter SATURATE, default 0, selecting wrap mode (0) or clamp mode (1).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port clear, input, 1 bit, synchronous clear to zero.
REQ-007 The block SHALL have port load, input, 1 bit, synchronous load of load_val.
REQ-008 The block SHALL have port load_val, input, WIDTH bits, the value captured on load.
REQ-009 The block SHALL have port en, input, 1 bit, the count enable.
REQ-010 The block SHALL have port up, input, 1 bit, the direction: 1 counts up, 0 counts down.
REQ-011 The block SHALL have port q, output, WIDTH bits, the registered count.
REQ-012 The block SHALL have port evt, output, 1 bit, a registered one-cycle boundary event (wrap or clamp).
REQ-013 The block SHALL have port at_max, output, 1 bit, combinational, high when q equals 2**WIDTH-1.
REQ-014 The block SHALL have port at_min, output, 1 bit, combinational, high when q equals 0.

Function
REQ-015 Per-edge priority SHALL be: clear, then load, then en; at most one action per cycle.
REQ-016 With clear=1, q SHALL become 0 and evt SHALL become 0 on the next edge, regardless of the other inputs.
REQ-017 With clear=0 and load=1, q SHALL become load_val and evt SHALL become 0; en and up are ignored.
REQ-018 With clear=0, load=0 and en=0, q SHALL hold and evt SHALL become 0.
REQ-019 With en=1 and up=1, the candidate SHALL be q+STEP, computed at WIDTH+1 bits.
REQ-020 With en=1 and up=0, the candidate SHALL be q-STEP, computed at WIDTH+1 bits.
REQ-021 A boundary crossing SHALL be detected when the candidate exceeds 2**WIDTH-1 (up) or goes below 0 (down).
REQ-022 Wrap mode (SATURATE=0): q SHALL take the candidate modulo 2**WIDTH.
REQ-023 Wrap mode: evt SHALL be 1 for exactly the cycle in which the wrapped value is first visible on q.
REQ-024 Clamp mode (SATURATE=1): on an up crossing, q SHALL become 2**WIDTH-1.
REQ-025 Clamp mode: on a down crossing, q SHALL become 0.
REQ-026 Clamp mode: evt SHALL pulse on each clamped edge, including repeated counting while already at the limit.
REQ-027 Latency from an input change to q/evt SHALL be one clock edge; at_max and at_min SHALL follow q with no added delay.
REQ-028 A step that lands exactly on 2**WIDTH-1 or on 0 without crossing SHALL NOT assert evt.
REQ-029 Reversing up on consecutive cycles SHALL be legal, with each edge evaluated independently.

Reset
REQ-030 Asserting rst SHALL immediately, without a clock, force q=0 and evt=0; at_min=1 and at_max=0 follow.
REQ-031 While rst is high, all synchronous inputs SHALL be ignored.
REQ-032 After rst deasserts, the first rising edge SHALL apply the normal priority rules.
REQ-033 Assertion of rst mid-count SHALL discard any pending increment.

Verification
REQ-034 Test 1, wrap up (WIDTH=8, STEP=1, SATURATE=0): load 8'hFE, then en=1/up=1 for 3 edges -> q=FF, 00, 01; evt=0, 1, 0.
REQ-035 Test 2, wrap down (STEP=3): load 8'h01, then en=1/up=0 for 1 edge -> q=8'hFE, evt=1; the next edge gives q=8'hFB, evt=0.
REQ-036 Test 3, clamp (SATURATE=1, STEP=4): load 8'hFD, then up for 2 edges -> q=FF, FF; evt=1, 1.
REQ-037 Test 4, clamp down: from q=2, down for 1 edge -> q=0, evt=1; at_min=1.
REQ-038 Test 5, priority: clear=1, load=1, load_val=8'h55, en=1 on the same edge -> q=0; then load=1 with en=1 -> q=8'h55.
REQ-039 Test 6, async reset: count to 8'h10, assert rst between edges -> q=0 before the next edge; hold clk for 2 edges with en=1 under reset -> q stays 0; deassert -> the next edge counts to 1.
